cp0_multi_lane: RTL and testbench
=================================

Name: cp0_multi_lane

Overview:
- Parametrised CP0 register file for the N-way issue MIPS core; it generalises the fixed dual-lane CP0 to LANES commit lanes.
- Sits at the commit (M/W) boundary and accepts per-lane MTC0 writes, MFC0 reads, exception/ERET commits and hardware interrupts.
- Resolves lane priority (lane 0 = oldest) and produces a registered one-cycle pipeline flush with its redirect PC.
- Adds timer-interrupt clear-on-Compare-write, a configurable Count prescaler and an interrupt-pending output.

Parameters:
- LANES, 2, number of commit lanes (1..4); lane 0 is the oldest instruction.
- COUNT_DIV, 2, clock cycles per Count increment (>=1).
- EXC_VECTOR, 32'hBFC00380, redirect PC for every exception other than ERET.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall_i  in  1  commit stage stalled; freezes architectural updates.
- we_i  in  LANES  per-lane MTC0 write enable.
- waddr_i  in  LANES*5  per-lane write register number.
- wdata_i  in  LANES*32  per-lane write data.
- raddr_i  in  LANES*5  per-lane MFC0 register number.
- rdata_o  out  LANES*32  per-lane read data; combinational, no bypass.
- int_i  in  6  hardware interrupt lines (IP7..IP2).
- exc_valid_i  in  LANES  lane commits an exception.
- exc_code_i  in  LANES*5  ExcCode for the lane.
- eret_i  in  LANES  lane commits an ERET.
- pc_i  in  LANES*32  lane instruction PC.
- in_ds_i  in  LANES  lane instruction is in a branch delay slot.
- badvaddr_i  in  LANES*32  faulting address for the lane.
- status_o  out  32  Status register.
- cause_o  out  32  Cause register.
- epc_o  out  32  EPC register.
- count_o  out  32  Count register.
- timer_int_o  out  1  timer interrupt flag.
- int_pending_o  out  1  an enabled interrupt is pending.
- flush_o  out  1  one-cycle pipeline flush.
- flush_pc_o  out  32  redirect PC accompanying flush_o.

Behaviour:
- Reset (async): Status=0x00400000, Cause=0, EPC=0, Count=0, Compare=0, BadVAddr=0, prescaler=0, timer_int_o=0, flush_o=0, flush_pc_o=0.
- Constant registers: PRId=0x004C0102, Config=0x00008000.
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16. Any other number reads 0 and ignores writes.
- Count and timer run independently of stall_i:
  - The prescaler counts 0..COUNT_DIV-1; Count increments on wrap, and Count wraps at 2^32.
  - timer_int_o sets the cycle after Count==Compare with Compare!=0.
  - A committed Compare write clears timer_int_o and overrides a same-cycle set.
- Cause:
  - Cause[15:10] samples int_i every cycle, with Cause[15] = int_i[5] | timer_int_o.
  - Cause[30] = timer_int_o.
  - Only Cause[9:8], [23] and [22] are writable.
- Winner selection:
  - Winner = lowest-index lane with exc_valid_i or eret_i set.
  - If a lane has both exc_valid_i and eret_i set, exc_valid_i wins.
- Writes:
  - Committed writes are those of lanes with index < winner, or all lanes if there is no winner.
  - Writes apply in ascending lane order, so a higher index wins on the same register.
  - A Count write also clears the prescaler and beats a same-cycle increment.
- Exception commit (applied after writes, overriding the same fields):
  - If Status.EXL=0: EPC = in_ds ? pc-4 : pc, and Cause[31] = in_ds.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Always: Status.EXL=1 and Cause[6:2]=code.
  - BadVAddr = badvaddr_i only for code 4 or 5.
  - Next cycle: flush_o=1 and flush_pc_o=EXC_VECTOR.
- ERET commit:
  - Status.EXL=0.
  - Next cycle: flush_o=1 and flush_pc_o = EPC after same-cycle older-lane writes.
- stall_i=1: no writes, exceptions or ERETs take effect, and flush_o=0 next cycle.
- flush_o is high for exactly one cycle per commit event; back-to-back events give consecutive pulses.
- int_pending_o = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]), combinational.
- An external interrupt is delivered as exc_code 0 on lane 0 by the core; this block does not self-inject it.

Test Plan:
- Reset then read all registers -> Status=0x00400000, PRId=0x004C0102, Config=0x00008000, others 0; flush_o=0.
- Lane0 exc code 8, pc=0x80001000, in_ds=1; lane1 write EPC=0x1234 -> EPC=0x80000FFC, Cause[31]=1, Cause[6:2]=8, lane1 write dropped; flush_o=1 with flush_pc_o=0xBFC00380 next cycle.
- Lane0 write EPC=0x80002000, lane1 eret -> Status.EXL=0; next cycle flush_pc_o=0x80002000.
- Compare=5, COUNT_DIV=2 -> timer_int_o rises after Count reaches 5 (about 10 cycles), Cause[30]=1; Compare write clears it in the same cycle.
- Lane0 exc code 4, badvaddr=0x80000003, with stall_i=1 -> no change and no flush; deassert stall_i -> BadVAddr=0x80000003, Cause[6:2]=4.
- Status=0x0000FF01, int_i=6'b000001 -> int_pending_o=1; exception with EXL=1 -> EPC unchanged, int_pending_o=0.

Source files
------------

// File: rtl/cp0_multi_lane.sv
// CP0 register file for an N-way commit stage: per-lane MTC0/MFC0, oldest-first
// exception/ERET resolution, prescaled Count/Compare timer and a registered flush.
module cp0_multi_lane #(
    parameter int          LANES      = 2,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic [LANES-1:0]      we_i,
    input  logic [LANES*5-1:0]    waddr_i,
    input  logic [LANES*32-1:0]   wdata_i,
    input  logic [LANES*5-1:0]    raddr_i,
    output logic [LANES*32-1:0]   rdata_o,
    input  logic [5:0]            int_i,
    input  logic [LANES-1:0]      exc_valid_i,
    input  logic [LANES*5-1:0]    exc_code_i,
    input  logic [LANES-1:0]      eret_i,
    input  logic [LANES*32-1:0]   pc_i,
    input  logic [LANES-1:0]      in_ds_i,
    input  logic [LANES*32-1:0]   badvaddr_i,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           count_o,
    output logic                  timer_int_o,
    output logic                  int_pending_o,
    output logic                  flush_o,
    output logic [31:0]           flush_pc_o
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
    localparam logic [31:0] PRID_VAL   = 32'h004C0102;
    localparam logic [31:0] CONFIG_VAL = 32'h00008000;

    logic [31:0]   status_q, status_d, epc_q, epc_d, count_q, count_d;
    logic [31:0]   compare_q, compare_d, badvaddr_q, badvaddr_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          timer_int_q, timer_int_d;
    logic          cause_bd_q, cause_bd_d, cause_iv_q, cause_iv_d, cause_wp_q, cause_wp_d;
    logic [1:0]    cause_ip_sw_q, cause_ip_sw_d;
    logic [4:0]    cause_exc_q, cause_exc_d;
    logic [5:0]    ip_hw_q, ip_hw_d;
    logic          flush_q, flush_d;
    logic [31:0]   flush_pc_q, flush_pc_d;

    logic          found, win_exc, win_ds;
    logic [4:0]    win_code;
    logic [31:0]   win_pc, win_bva;
    logic [31:0]   wdata_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q      <= 32'h00400000;
            epc_q         <= '0;
            count_q       <= '0;
            compare_q     <= '0;
            badvaddr_q    <= '0;
            presc_q       <= '0;
            timer_int_q   <= 1'b0;
            cause_bd_q    <= 1'b0;
            cause_iv_q    <= 1'b0;
            cause_wp_q    <= 1'b0;
            cause_ip_sw_q <= '0;
            cause_exc_q   <= '0;
            ip_hw_q       <= '0;
            flush_q       <= 1'b0;
            flush_pc_q    <= '0;
        end else begin
            status_q      <= status_d;
            epc_q         <= epc_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            badvaddr_q    <= badvaddr_d;
            presc_q       <= presc_d;
            timer_int_q   <= timer_int_d;
            cause_bd_q    <= cause_bd_d;
            cause_iv_q    <= cause_iv_d;
            cause_wp_q    <= cause_wp_d;
            cause_ip_sw_q <= cause_ip_sw_d;
            cause_exc_q   <= cause_exc_d;
            ip_hw_q       <= ip_hw_d;
            flush_q       <= flush_d;
            flush_pc_q    <= flush_pc_d;
        end
    end

    // Lanes are walked oldest first: writes commit until the first exc/ERET lane is seen.
    always_comb begin
        status_d      = status_q;
        epc_d         = epc_q;
        compare_d     = compare_q;
        badvaddr_d    = badvaddr_q;
        cause_bd_d    = cause_bd_q;
        cause_iv_d    = cause_iv_q;
        cause_wp_d    = cause_wp_q;
        cause_ip_sw_d = cause_ip_sw_q;
        cause_exc_d   = cause_exc_q;
        ip_hw_d       = int_i;
        flush_d       = 1'b0;
        flush_pc_d    = flush_pc_q;
        presc_d       = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        count_d       = (presc_q == PRESC_MAX) ? count_q + 32'd1 : count_q;
        timer_int_d   = timer_int_q | ((count_q == compare_q) && (compare_q != '0));
        found         = 1'b0;
        win_exc       = 1'b0;
        win_ds        = 1'b0;
        win_code      = '0;
        win_pc        = '0;
        win_bva       = '0;
        wdata_l       = '0;
        for (int l = 0; l < LANES; l++) begin
            if (!found && (exc_valid_i[l] || eret_i[l])) begin
                found    = 1'b1;
                win_exc  = exc_valid_i[l];
                win_ds   = in_ds_i[l];
                win_code = exc_code_i[l*5 +: 5];
                win_pc   = pc_i[l*32 +: 32];
                win_bva  = badvaddr_i[l*32 +: 32];
            end
            if (!found && !stall_i && we_i[l]) begin
                wdata_l = wdata_i[l*32 +: 32];
                case (waddr_i[l*5 +: 5])
                    5'd8:  badvaddr_d = wdata_l;
                    5'd9: begin
                        count_d = wdata_l;
                        presc_d = '0;
                    end
                    5'd11: begin
                        compare_d   = wdata_l;
                        timer_int_d = 1'b0;
                    end
                    5'd12: status_d = wdata_l;
                    5'd13: begin
                        cause_iv_d    = wdata_l[23];
                        cause_wp_d    = wdata_l[22];
                        cause_ip_sw_d = wdata_l[9:8];
                    end
                    5'd14: epc_d = wdata_l;
                    default: ;
                endcase
            end
        end
        if (found && !stall_i) begin
            flush_d = 1'b1;
            if (win_exc) begin
                if (!status_d[1]) begin
                    epc_d      = win_ds ? win_pc - 32'd4 : win_pc;
                    cause_bd_d = win_ds;
                end
                status_d[1] = 1'b1;
                cause_exc_d = win_code;
                if (win_code == 5'd4 || win_code == 5'd5)
                    badvaddr_d = win_bva;
                flush_pc_d = EXC_VECTOR;
            end else begin
                status_d[1] = 1'b0;
                flush_pc_d  = epc_d;
            end
        end
    end

    assign cause_o = {cause_bd_q, timer_int_q, 6'b0, cause_iv_q, cause_wp_q, 6'b0,
                      ip_hw_q[5] | timer_int_q, ip_hw_q[4:0], cause_ip_sw_q, 1'b0,
                      cause_exc_q, 2'b00};

    always_comb begin
        rdata_o = '0;
        for (int l = 0; l < LANES; l++) begin
            case (raddr_i[l*5 +: 5])
                5'd8:    rdata_o[l*32 +: 32] = badvaddr_q;
                5'd9:    rdata_o[l*32 +: 32] = count_q;
                5'd11:   rdata_o[l*32 +: 32] = compare_q;
                5'd12:   rdata_o[l*32 +: 32] = status_q;
                5'd13:   rdata_o[l*32 +: 32] = cause_o;
                5'd14:   rdata_o[l*32 +: 32] = epc_q;
                5'd15:   rdata_o[l*32 +: 32] = PRID_VAL;
                5'd16:   rdata_o[l*32 +: 32] = CONFIG_VAL;
                default: rdata_o[l*32 +: 32] = '0;
            endcase
        end
    end

    assign status_o      = status_q;
    assign epc_o         = epc_q;
    assign count_o       = count_q;
    assign timer_int_o   = timer_int_q;
    assign flush_o       = flush_q;
    assign flush_pc_o    = flush_pc_q;
    assign int_pending_o = status_q[0] & ~status_q[1] & (|(cause_o[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_multi_lane.sv
// Directed bench for cp0_multi_lane: register checks inline, flush redirects
// checked by a negedge monitor against a queue of expected PCs.
module tb_cp0_multi_lane;

    localparam int LANES = 2;
    localparam logic [31:0] EXC_VEC = 32'hBFC00380;

    logic                clk = 1'b0;
    logic                rst;
    logic                stall_i;
    logic [LANES-1:0]    we_i;
    logic [LANES*5-1:0]  waddr_i;
    logic [LANES*32-1:0] wdata_i;
    logic [LANES*5-1:0]  raddr_i;
    logic [LANES*32-1:0] rdata_o;
    logic [5:0]          int_i;
    logic [LANES-1:0]    exc_valid_i;
    logic [LANES*5-1:0]  exc_code_i;
    logic [LANES-1:0]    eret_i;
    logic [LANES*32-1:0] pc_i;
    logic [LANES-1:0]    in_ds_i;
    logic [LANES*32-1:0] badvaddr_i;
    logic [31:0]         status_o, cause_o, epc_o, count_o, flush_pc_o;
    logic                timer_int_o, int_pending_o, flush_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] flushQueue[$];
    int n;

    cp0_multi_lane #(.LANES(LANES), .COUNT_DIV(2), .EXC_VECTOR(EXC_VEC)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .eret_i(eret_i),
        .pc_i(pc_i), .in_ds_i(in_ds_i), .badvaddr_i(badvaddr_i),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
        .timer_int_o(timer_int_o), .int_pending_o(int_pending_o),
        .flush_o(flush_o), .flush_pc_o(flush_pc_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        stall_i     = 1'b0;
        we_i        = '0;
        waddr_i     = '0;
        wdata_i     = '0;
        exc_valid_i = '0;
        exc_code_i  = '0;
        eret_i      = '0;
        pc_i        = '0;
        in_ds_i     = '0;
        badvaddr_i  = '0;
    endtask

    // Commits whatever vector is currently driven at the next rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        clearInputs();
    endtask

    task automatic laneWrite(input int lane, input logic [4:0] addr, input logic [31:0] data);
        we_i[lane]              = 1'b1;
        waddr_i[lane*5 +: 5]    = addr;
        wdata_i[lane*32 +: 32]  = data;
    endtask

    task automatic laneExc(input int lane, input logic [4:0] code, input logic [31:0] pc,
                           input logic ds, input logic [31:0] bva);
        exc_valid_i[lane]         = 1'b1;
        exc_code_i[lane*5 +: 5]   = code;
        pc_i[lane*32 +: 32]       = pc;
        in_ds_i[lane]             = ds;
        badvaddr_i[lane*32 +: 32] = bva;
    endtask

    task automatic checkReg(input string name, input int lane, input logic [4:0] addr, input logic [31:0] expected);
        raddr_i[lane*5 +: 5] = addr;
        #1;
        checkOutput(name, rdata_o[lane*32 +: 32], expected);
    endtask

    always @(negedge clk) begin
        if (!rst && flush_o) begin
            if (flushQueue.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL flush_unexpected actual=%h required=no flush", flush_pc_o);
            end else begin
                checkOutput("flush_pc", flush_pc_o, flushQueue.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        int_i = '0;
        raddr_i = '0;
        clearInputs();
        repeat (3) @(negedge clk);
        checkOutput("rst_status", status_o, 32'h00400000);
        checkOutput("rst_cause", cause_o, 32'h0);
        checkOutput("rst_epc", epc_o, 32'h0);
        checkOutput("rst_count", count_o, 32'h0);
        checkOutput("rst_flush", {31'b0, flush_o}, 32'h0);
        checkReg("rst_prid", 0, 5'd15, 32'h004C0102);
        checkReg("rst_config", 0, 5'd16, 32'h00008000);
        checkReg("rst_badvaddr", 0, 5'd8, 32'h0);
        checkReg("rst_compare", 0, 5'd11, 32'h0);
        checkReg("rst_unmapped", 0, 5'd20, 32'h0);
        checkReg("rst_prid_lane1", 1, 5'd15, 32'h004C0102);
        @(negedge clk);
        rst = 1'b0;

        // Lane 0 exception in delay slot drops the younger lane-1 EPC write
        laneExc(0, 5'd8, 32'h80001000, 1'b1, 32'h0);
        laneWrite(1, 5'd14, 32'h00001234);
        flushQueue.push_back(EXC_VEC);
        applyStimulus();
        checkOutput("exc_flush", {31'b0, flush_o}, 32'h1);
        checkOutput("exc_epc", epc_o, 32'h80000FFC);
        checkOutput("exc_cause", cause_o, 32'h80000020);
        checkOutput("exc_status", status_o, 32'h00400002);

        // Older-lane EPC write is visible to a same-cycle ERET
        laneWrite(0, 5'd14, 32'h80002000);
        eret_i[1] = 1'b1;
        flushQueue.push_back(32'h80002000);
        applyStimulus();
        checkOutput("eret_flush", {31'b0, flush_o}, 32'h1);
        checkOutput("eret_status", status_o, 32'h00400000);
        checkOutput("eret_epc", epc_o, 32'h80002000);

        // Exception and ERET on the same lane: the exception wins
        laneExc(0, 5'd10, 32'h80003000, 1'b0, 32'h0);
        eret_i[0] = 1'b1;
        flushQueue.push_back(EXC_VEC);
        applyStimulus();
        checkOutput("both_status", status_o, 32'h00400002);
        checkOutput("both_epc", epc_o, 32'h80003000);
        checkOutput("both_cause", cause_o, 32'h00000028);
        eret_i[0] = 1'b1;
        flushQueue.push_back(32'h80003000);
        applyStimulus();
        checkOutput("eret2_status", status_o, 32'h00400000);

        // Same register written by both lanes: the younger lane lands last
        laneWrite(0, 5'd14, 32'h00000011);
        laneWrite(1, 5'd14, 32'h00000022);
        applyStimulus();
        checkOutput("write_order_epc", epc_o, 32'h00000022);
        checkOutput("write_noflush", {31'b0, flush_o}, 32'h0);

        // Timer: Count=0 and Compare=5 written together, timer rises after Count reaches 5
        laneWrite(0, 5'd9, 32'h0);
        laneWrite(1, 5'd11, 32'd5);
        applyStimulus();
        n = 1;
        while (!timer_int_o && n < 40) begin
            applyStimulus();
            n++;
        end
        checkOutput("timer_latency", n, 32'd12);
        checkOutput("timer_count", count_o, 32'd5);
        checkOutput("timer_cause", cause_o, 32'h40008028);
        laneWrite(0, 5'd11, 32'h0);
        applyStimulus();
        checkOutput("timer_clear", {31'b0, timer_int_o}, 32'h0);

        // Count wraps at 2^32 after COUNT_DIV cycles
        laneWrite(0, 5'd9, 32'hFFFFFFFF);
        applyStimulus();
        checkOutput("wrap_pre", count_o, 32'hFFFFFFFF);
        applyStimulus();
        checkOutput("wrap_hold", count_o, 32'hFFFFFFFF);
        applyStimulus();
        checkOutput("wrap_zero", count_o, 32'h0);
        checkOutput("wrap_no_timer", {31'b0, timer_int_o}, 32'h0);

        // Stalled exception has no effect, then commits once released
        stall_i = 1'b1;
        laneExc(0, 5'd4, 32'h80004000, 1'b0, 32'h80000003);
        applyStimulus();
        checkOutput("stall_flush", {31'b0, flush_o}, 32'h0);
        checkOutput("stall_status", status_o, 32'h00400000);
        checkReg("stall_badvaddr", 0, 5'd8, 32'h0);
        laneExc(0, 5'd4, 32'h80004000, 1'b0, 32'h80000003);
        flushQueue.push_back(EXC_VEC);
        applyStimulus();
        checkReg("unstall_badvaddr", 0, 5'd8, 32'h80000003);
        checkOutput("unstall_cause", cause_o, 32'h00000010);
        checkOutput("unstall_epc", epc_o, 32'h80004000);

        // Back-to-back exception while EXL=1 keeps EPC and BadVAddr
        laneExc(1, 5'd12, 32'h80004100, 1'b1, 32'h12345678);
        flushQueue.push_back(EXC_VEC);
        applyStimulus();
        checkOutput("b2b_flush", {31'b0, flush_o}, 32'h1);
        checkOutput("b2b_epc", epc_o, 32'h80004000);
        checkOutput("b2b_cause", cause_o, 32'h00000030);
        checkReg("b2b_badvaddr", 0, 5'd8, 32'h80000003);
        eret_i[0] = 1'b1;
        flushQueue.push_back(32'h80004000);
        applyStimulus();

        // Interrupt pending with IE set and EXL clear
        laneWrite(0, 5'd12, 32'h0000FF01);
        int_i = 6'b000001;
        applyStimulus();
        checkOutput("intp_set", {31'b0, int_pending_o}, 32'h1);
        checkOutput("intp_cause", cause_o, 32'h00000430);
        laneExc(0, 5'd0, 32'h80005000, 1'b0, 32'h0);
        flushQueue.push_back(EXC_VEC);
        applyStimulus();
        checkOutput("intp_exc_epc", epc_o, 32'h80005000);
        checkOutput("intp_exc_status", status_o, 32'h0000FF03);
        checkOutput("intp_masked", {31'b0, int_pending_o}, 32'h0);
        laneExc(0, 5'd13, 32'h80006000, 1'b1, 32'h0);
        flushQueue.push_back(EXC_VEC);
        applyStimulus();
        checkOutput("exl_epc_kept", epc_o, 32'h80005000);
        checkOutput("exl_cause", cause_o, 32'h00000434);
        checkOutput("exl_intp", {31'b0, int_pending_o}, 32'h0);

        // Cause write touches only its writable bits; PRId ignores writes
        laneWrite(0, 5'd13, 32'hFFFFFFFF);
        laneWrite(1, 5'd15, 32'h0);
        applyStimulus();
        checkOutput("cause_mask", cause_o, 32'h00C00734);
        checkReg("prid_ro", 1, 5'd15, 32'h004C0102);

        repeat (2) applyStimulus();
        checkOutput("flush_queue_empty", flushQueue.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
